change_dispenser: RTL and testbench

//   Downstream actuator stage of the vending controller. Consumes the FSM's soda/change

---
 rtl/change_dispenser.sv | 123 ++++++++++++
 tb/tb_change_dispenser.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Vend/nickel actuator sequencer: queues vend and change requests, then pulses the motor and the solenoid.
// Optional tube-empty stall on nickel ejection when CHANGE_DISPENSER_TUBE_SENSE_EN is defined.
module change_dispenser #(
  parameter int VEND_CYC  = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       soda_i,
  input  logic [2:0] change_i,
`ifdef CHANGE_DISPENSER_TUBE_SENSE_EN
  input  logic       tube_empty_i,
  output logic       stall_o,
`endif
  output logic       vend_o,
  output logic       nickel_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int MAX_A   = (VEND_CYC > PULSE_CYC) ? VEND_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int SW      = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, VEND, EJECT, GAP} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [CNT_W-1:0] vend_pend, nick_pend, vend_nxt, nick_nxt;
  logic             overflow_nxt;
  logic             decide, vend_dec, nick_dec, nick_ok;
  logic [SW-1:0]    vend_sum, nick_sum;

`ifdef CHANGE_DISPENSER_TUBE_SENSE_EN
  assign nick_ok = ~tube_empty_i;
  assign stall_o = (state == IDLE) & (nick_pend != '0) & tube_empty_i;
`else
  assign nick_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    decide    = 1'b0;
    vend_dec  = 1'b0;
    nick_dec  = 1'b0;
    case (state)
      IDLE: decide = 1'b1;
      VEND, EJECT: begin
        if (timer == '0) begin
          state_nxt = GAP;
          timer_nxt = TW'(GAP_CYC - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      GAP: begin
        if (timer == '0) decide = 1'b1;
        else             timer_nxt = timer - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
    // Vends outrank nickels; an empty tube parks the block in IDLE with nickels still owed
    if (decide) begin
      if (vend_pend != '0) begin
        state_nxt = VEND;
        timer_nxt = TW'(VEND_CYC - 1);
        vend_dec  = 1'b1;
      end else if ((nick_pend != '0) && nick_ok) begin
        state_nxt = EJECT;
        timer_nxt = TW'(PULSE_CYC - 1);
        nick_dec  = 1'b1;
      end else begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    end
  end

  always_comb begin
    vend_sum     = SW'(vend_pend) + SW'(soda_i) - SW'(vend_dec);
    nick_sum     = SW'(nick_pend) + (soda_i ? SW'(change_i) : '0) - SW'(nick_dec);
    vend_nxt     = vend_sum[CNT_W-1:0];
    nick_nxt     = nick_sum[CNT_W-1:0];
    overflow_nxt = overflow_o;
    if (vend_sum > SW'(CNT_MAX)) begin
      vend_nxt     = CNT_MAX;
      overflow_nxt = 1'b1;
    end
    if (nick_sum > SW'(CNT_MAX)) begin
      nick_nxt     = CNT_MAX;
      overflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      timer      <= '0;
      vend_pend  <= '0;
      nick_pend  <= '0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      vend_pend  <= vend_nxt;
      nick_pend  <= nick_nxt;
      overflow_o <= overflow_nxt;
    end
  end

  assign vend_o   = (state == VEND);
  assign nickel_o = (state == EJECT);
  assign busy_o   = (state != IDLE) | (vend_pend != '0) | (nick_pend != '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected pulses are queued as requests are driven
// and matched against observed vend/nickel pulses (start cycle and length).
module tb_change_dispenser;

  localparam int VEND_CYC  = 8;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 4;
  localparam int CNT_W     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soda = 1'b0;
  logic [2:0] change = 3'd0;
  logic       vend, nickel, busy, overflow;
`ifdef CHANGE_DISPENSER_TUBE_SENSE_EN
  logic       tube_empty = 1'b0;
  logic       stall;
`endif

  always #5 clk = ~clk;

  change_dispenser #(
    .VEND_CYC (VEND_CYC),
    .PULSE_CYC(PULSE_CYC),
    .GAP_CYC  (GAP_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .soda_i      (soda),
    .change_i    (change),
`ifdef CHANGE_DISPENSER_TUBE_SENSE_EN
    .tube_empty_i(tube_empty),
    .stall_o     (stall),
`endif
    .vend_o      (vend),
    .nickel_o    (nickel),
    .busy_o      (busy),
    .overflow_o  (overflow)
  );

  typedef struct {
    int kind;
    int start;
    int len;
  } pulse_t;

  pulse_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  bit both_seen = 1'b0;
  logic prev_vend = 1'b0;
  logic prev_nick = 1'b0;
  int vend_start = 0;
  int nick_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc - base);
    end
  endtask

  task automatic score_pulse(input int kind, input int start, input int len);
    pulse_t e;
    string nm;
    nm = (kind == 1) ? "nickel" : "vend";
    if (exp_q.size() == 0) begin
      check_output({nm, "_unexpected_pulse_at"}, start, -1);
    end else begin
      e = exp_q.pop_front();
      check_output({nm, "_kind"}, kind, e.kind);
      check_output({nm, "_start"}, start, e.start);
      check_output({nm, "_len"}, len, e.len);
    end
  endtask

  // Pulse monitor samples on the falling edge, away from register updates
  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    if (vend && nickel) both_seen = 1'b1;
    if (vend && !prev_vend) vend_start = rel;
    if (!vend && prev_vend) score_pulse(0, vend_start, rel - vend_start);
    if (nickel && !prev_nick) nick_start = rel;
    if (!nickel && prev_nick) score_pulse(1, nick_start, rel - nick_start);
    prev_vend = vend;
    prev_nick = nickel;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_to(input int c);
    while (cyc - base < c) step(1);
  endtask

  task automatic push_pulse(input int kind, input int start, input int len);
    pulse_t e;
    e.kind  = kind;
    e.start = start;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic s, input logic [2:0] ch);
    soda   = s;
    change = ch;
  endtask

  task automatic start_test(input string name);
    rst = 1'b1;
    apply_stimulus(1'b0, 3'd0);
    step(1);
    rst = 1'b0;
    both_seen = 1'b0;
    base = cyc;
    $display("[TB] test %s", name);
  endtask

  task automatic finish_test(input string name, input int busy_off);
    go_to(busy_off - 1);
    check_output({name, "_busy_last"}, int'(busy), 1);
    go_to(busy_off);
    check_output({name, "_busy_off"}, int'(busy), 0);
    step(2);
    check_output({name, "_pulses_left"}, exp_q.size(), 0);
    check_output({name, "_exclusive"}, int'(both_seen), 0);
    exp_q.delete();
  endtask

  initial begin
    // Test 1: single vend, no change
    start_test("t1");
    check_output("rst_vend", int'(vend), 0);
    check_output("rst_nickel", int'(nickel), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_overflow", int'(overflow), 0);
    push_pulse(0, 2, VEND_CYC);
    apply_stimulus(1'b1, 3'd0);
    step(1);
    apply_stimulus(1'b0, 3'd5);
    check_output("t1_busy_c1", int'(busy), 1);
    finish_test("t1", 14);

    // Test 2: vend plus three nickels
    start_test("t2");
    push_pulse(0, 2, VEND_CYC);
    push_pulse(1, 14, PULSE_CYC);
    push_pulse(1, 22, PULSE_CYC);
    push_pulse(1, 30, PULSE_CYC);
    apply_stimulus(1'b1, 3'd3);
    step(1);
    apply_stimulus(1'b0, 3'd0);
    finish_test("t2", 38);

    // Test 3: second vend arrives mid-change and jumps ahead of the remaining nickels
    start_test("t3");
    push_pulse(0, 2, VEND_CYC);
    push_pulse(1, 14, PULSE_CYC);
    push_pulse(0, 22, VEND_CYC);
    push_pulse(1, 34, PULSE_CYC);
    push_pulse(1, 42, PULSE_CYC);
    apply_stimulus(1'b1, 3'd3);
    step(1);
    apply_stimulus(1'b0, 3'd0);
    go_to(15);
    apply_stimulus(1'b1, 3'd0);
    step(1);
    apply_stimulus(1'b0, 3'd0);
    finish_test("t3", 50);

    // Test 4: three back-to-back requests of 7 nickels saturate the counter at 15
    start_test("t4");
    for (int k = 0; k < 3; k++) push_pulse(0, 2 + 12 * k, VEND_CYC);
    for (int k = 0; k < 15; k++) push_pulse(1, 38 + 8 * k, PULSE_CYC);
    apply_stimulus(1'b1, 3'd7);
    step(1);
    apply_stimulus(1'b1, 3'd7);
    step(1);
    check_output("t4_overflow_c2", int'(overflow), 0);
    apply_stimulus(1'b1, 3'd7);
    step(1);
    apply_stimulus(1'b0, 3'd0);
    check_output("t4_overflow_c3", int'(overflow), 1);
    go_to(100);
    check_output("t4_overflow_sticky", int'(overflow), 1);
    finish_test("t4", 158);

    // Test 5: reset mid-vend aborts the pulse and drops the owed nickels
    start_test("t5");
    push_pulse(0, 2, 4);
    apply_stimulus(1'b1, 3'd3);
    step(1);
    apply_stimulus(1'b0, 3'd0);
    go_to(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_output("t5_vend_c6", int'(vend), 0);
    check_output("t5_nickel_c6", int'(nickel), 0);
    check_output("t5_busy_c6", int'(busy), 0);
    check_output("t5_overflow_c6", int'(overflow), 0);
    step(40);
    check_output("t5_pulses_left", exp_q.size(), 0);
    exp_q.delete();

`ifdef CHANGE_DISPENSER_TUBE_SENSE_EN
    // Test 6: empty tube holds the nickels until it is refilled
    start_test("t6");
    push_pulse(0, 2, VEND_CYC);
    push_pulse(1, 41, PULSE_CYC);
    push_pulse(1, 49, PULSE_CYC);
    push_pulse(1, 57, PULSE_CYC);
    tube_empty = 1'b1;
    apply_stimulus(1'b1, 3'd3);
    step(1);
    apply_stimulus(1'b0, 3'd0);
    go_to(13);
    check_output("t6_stall_c13", int'(stall), 0);
    go_to(14);
    check_output("t6_stall_c14", int'(stall), 1);
    go_to(39);
    check_output("t6_stall_c39", int'(stall), 1);
    check_output("t6_nickel_c39", int'(nickel), 0);
    check_output("t6_busy_c39", int'(busy), 1);
    go_to(40);
    tube_empty = 1'b0;
    #1;
    check_output("t6_stall_c40", int'(stall), 0);
    finish_test("t6", 65);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
